datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Minimal single-bus register datapath: three WIDTH-bit registers (RA, RB, RZ) share one internal bus.
- Each register has an output enable onto the bus and a load enable from the bus.
- An adder forms bus + AddImmediate, loaded into RZ. RegisterAImmediate drives the bus when no register drives it, which allows load-immediate.
- Sits under a control unit or bench that sequences out/in enables per T-state.

Parameters:
- WIDTH, 8, data width of the bus, registers, immediates and adder.

Ports:
- clock  input  1  system clock; all registers update on the rising edge.
- clear  input  1  reset, asynchronous and active-high; clears RA, RB, RZ.
- AddImmediate  input  WIDTH  second adder operand.
- RegisterAImmediate  input  WIDTH  immediate bus source, used when no register out-enable is asserted.
- RZout  input  1  RZ drives the bus.
- RAout  input  1  RA drives the bus.
- RBout  input  1  RB drives the bus.
- RAin  input  1  RA loads the bus on the rising edge.
- RBin  input  1  RB loads the bus on the rising edge.
- RZin  input  1  RZ loads (bus + AddImmediate) on the rising edge.
- bus_out  output  WIDTH  current bus value (combinational).
- ra_q  output  WIDTH  RA contents.
- rb_q  output  WIDTH  RB contents.
- rz_q  output  WIDTH  RZ contents.
- bus_conflict  output  1  more than one out-enable asserted (see Optional Feature).

Port order is fixed as listed. Existing controllers connect the first ten ports positionally.

Behaviour:
- Reset: clear=1 forces RA=RB=RZ=0 immediately, independent of clock, and holds them while asserted. Load enables are ignored during reset. Release takes effect at the next rising edge.
- Bus mux is combinational, with fixed priority RZout > RBout > RAout > RegisterAImmediate.
  - With no out-enable asserted, bus = RegisterAImmediate.
  - If that immediate is 0, bus = 0.
- Adder: sum = (bus + AddImmediate) mod 2^WIDTH. Carry is discarded; 0xFF + 0x02 = 0x01.
- Register loads happen on the rising clock edge when the enable is high:
  - RA <= bus (if RAin).
  - RB <= bus (if RBin).
  - RZ <= sum (if RZin).
  - Otherwise each register holds its value.
- Latency:
  - One clock from an in-enable to the new value visible on the *_q outputs.
  - The bus, and therefore the adder, is zero-latency.
- Simultaneous events:
  - Several in-enables in the same cycle all load in the same edge, each from the same pre-edge bus value.
  - A register both out-enabled and in-enabled reloads its own value; for RZ it accumulates: RZ <= RZ + AddImmediate.
- Multiple out-enables resolve by the priority rule; no X is ever driven.
- Reset mid-operation: an asserted clear overrides any pending load in the same cycle.

Optional Feature:
- Macro DATAPATH_BUS_CONFLICT_EN.
- Defined: bus_conflict is high combinationally whenever two or more of RZout/RAout/RBout are high. In simulation, a $error is also issued on each rising edge where this holds. Bus resolution is unchanged.
- Undefined: bus_conflict is tied to 0 and no checking logic is generated.

Decomposition:
- Package datapath_pkg holds:
  - DATA_W default constant (8).
  - Data word typedef.
  - Enum for bus source: SRC_IMM, SRC_RA, SRC_RB, SRC_RZ.
- Sub-module datapath_reg: WIDTH-bit register with async active-high clear and synchronous load enable. It is instantiated three times (RA, RB, RZ).
- Bus mux, adder and conflict detect stay in the top.

Test Plan:
- Reset: drive clear=1 mid-cycle with arbitrary enables -> ra_q=rb_q=rz_q=0x00 immediately; values stay 0 while clear=1.
- Load immediate: RegisterAImmediate=0x05, RAin=1, no out-enables, one edge -> ra_q=0x05; rb_q and rz_q unchanged at 0.
- Add immediate: RAout=1, AddImmediate=0x05, RZin=1, one edge -> bus_out=0x05 during the cycle; rz_q=0x0A.
- Move: RZout=1, RBin=1, one edge -> rb_q=0x0A; ra_q still 0x05.
- Wrap and accumulate: RA=0xFF, RAout=1, AddImmediate=0x02, RZin=1 -> rz_q=0x01. Then RZout=1, RZin=1, AddImmediate=0x03 -> rz_q=0x04.
- Priority and conflict: RZ=0x0A, RA=0x05, RZout=RAout=1, RBin=1 -> rb_q=0x0A. bus_conflict=1 with the macro defined, 0 without. Asserting clear in the same cycle instead -> rb_q=0x00.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg
// Shared definitions for the single-bus register datapath:
//   DATA_W      default data width of bus, registers, immediates and adder
//   data_t      data word of the default width
//   bus_src_e   which source currently owns the internal bus
//   out_enable_count  counts how many register out-enables are asserted

package datapath_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        SRC_IMM = 2'd0,
        SRC_RA  = 2'd1,
        SRC_RB  = 2'd2,
        SRC_RZ  = 2'd3
    } bus_src_e;

    // Population count of the three register out-enables; two or more
    // means several registers are trying to own the bus at once.
    function automatic logic [1:0] out_enable_count(input logic rz_out,
                                                    input logic ra_out,
                                                    input logic rb_out);
        return {1'b0, rz_out} + {1'b0, ra_out} + {1'b0, rb_out};
    endfunction

endpackage

// File: rtl/datapath_reg.sv
// datapath_reg
// WIDTH-bit storage register with asynchronous active-high clear and a
// synchronous load enable. Used for RA, RB and RZ.
// Ports:
//   clock  rising-edge clock
//   clear  asynchronous active-high clear, overrides load
//   load   capture d on the rising edge when high
//   d      data in
//   q      register contents

module datapath_reg
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over a pending load in the same cycle; otherwise hold.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath.sv
// datapath
// Minimal single-bus register datapath. RA, RB and RZ share one internal
// bus; each has an out-enable onto the bus and a load enable from it. RZ
// loads bus + AddImmediate. When no register drives the bus the immediate
// RegisterAImmediate does, which gives load-immediate.
// Optional build macro: DATAPATH_BUS_CONFLICT_EN enables the bus_conflict
// flag (and a simulation-only $error); otherwise bus_conflict is tied low.
// Ports (order is fixed, controllers connect the first ten positionally):
//   clock, clear                rising-edge clock, async active-high clear
//   AddImmediate                second adder operand
//   RegisterAImmediate          bus source when no register is out-enabled
//   RZout, RAout, RBout         register out-enables (priority RZ>RB>RA)
//   RAin, RBin, RZin            register load enables
//   bus_out                     current bus value (combinational)
//   ra_q, rb_q, rz_q            register contents
//   bus_conflict                two or more out-enables asserted

module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] AddImmediate,
    input  logic [WIDTH-1:0] RegisterAImmediate,
    input  logic             RZout,
    input  logic             RAout,
    input  logic             RBout,
    input  logic             RAin,
    input  logic             RBin,
    input  logic             RZin,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] ra_q,
    output logic [WIDTH-1:0] rb_q,
    output logic [WIDTH-1:0] rz_q,
    output logic             bus_conflict
);

    bus_src_e         bus_src;
    logic [WIDTH-1:0] sum;

    // Fixed-priority bus ownership, so several out-enables never produce X.
    always_comb begin
        bus_src = SRC_IMM;
        if (RZout) begin
            bus_src = SRC_RZ;
        end else if (RBout) begin
            bus_src = SRC_RB;
        end else if (RAout) begin
            bus_src = SRC_RA;
        end
    end

    always_comb begin
        bus_out = RegisterAImmediate;
        case (bus_src)
            SRC_RZ:  bus_out = rz_q;
            SRC_RB:  bus_out = rb_q;
            SRC_RA:  bus_out = ra_q;
            default: bus_out = RegisterAImmediate;
        endcase
    end

    // Carry is intentionally dropped; the sum wraps at WIDTH bits.
    assign sum = bus_out + AddImmediate;

    datapath_reg #(.WIDTH(WIDTH)) u_ra (
        .clock (clock),
        .clear (clear),
        .load  (RAin),
        .d     (bus_out),
        .q     (ra_q)
    );

    datapath_reg #(.WIDTH(WIDTH)) u_rb (
        .clock (clock),
        .clear (clear),
        .load  (RBin),
        .d     (bus_out),
        .q     (rb_q)
    );

    datapath_reg #(.WIDTH(WIDTH)) u_rz (
        .clock (clock),
        .clear (clear),
        .load  (RZin),
        .d     (sum),
        .q     (rz_q)
    );

`ifdef DATAPATH_BUS_CONFLICT_EN
    assign bus_conflict = (out_enable_count(RZout, RAout, RBout) > 2'd1);
`ifndef SYNTHESIS
    // Flag every edge on which several registers contend for the bus.
    always @(posedge clock) begin
        if (bus_conflict) begin
            $error("datapath: multiple bus out-enables RZout=%b RAout=%b RBout=%b",
                   RZout, RAout, RBout);
        end
    end
`endif
`else
    assign bus_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_datapath.sv
// tb_datapath
// Self-checking bench for datapath: a directed walk through load-immediate,
// add, move, wrap, accumulate, priority and clear, followed by randomized
// cycles, with a reference model of the register file compared every cycle.

module tb_datapath;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         clear;
    logic [W-1:0] AddImmediate;
    logic [W-1:0] RegisterAImmediate;
    logic         RZout, RAout, RBout;
    logic         RAin, RBin, RZin;
    logic [W-1:0] bus_out, ra_q, rb_q, rz_q;
    logic         bus_conflict;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference register contents
    logic [W-1:0] m_ra, m_rb, m_rz;

    datapath #(.WIDTH(W)) dut (
        .clock              (clock),
        .clear              (clear),
        .AddImmediate       (AddImmediate),
        .RegisterAImmediate (RegisterAImmediate),
        .RZout              (RZout),
        .RAout              (RAout),
        .RBout              (RBout),
        .RAin               (RAin),
        .RBin               (RBin),
        .RZin               (RZin),
        .bus_out            (bus_out),
        .ra_q               (ra_q),
        .rb_q               (rb_q),
        .rz_q               (rz_q),
        .bus_conflict       (bus_conflict)
    );

    always #5 clock = ~clock;

    // Bus value from the priority rule: RZ, then RB, then RA, else immediate.
    function automatic logic [W-1:0] model_bus();
        if (RZout) return m_rz;
        if (RBout) return m_rb;
        if (RAout) return m_ra;
        return RegisterAImmediate;
    endfunction

    function automatic logic [W-1:0] model_sum();
        int s;
        s = (int'(model_bus()) + int'(AddImmediate)) % (1 << W);
        return s[W-1:0];
    endfunction

    function automatic logic model_conflict();
`ifdef DATAPATH_BUS_CONFLICT_EN
        return (int'(RZout) + int'(RAout) + int'(RBout)) >= 2;
`else
        return 1'b0;
`endif
    endfunction

    // Reference register file: everything loads from the pre-edge bus.
    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_ra <= '0;
            m_rb <= '0;
            m_rz <= '0;
        end else begin
            if (RAin) m_ra <= model_bus();
            if (RBin) m_rb <= model_bus();
            if (RZin) m_rz <= model_sum();
        end
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    task automatic checkOutput();
        check("bus_out",      32'(bus_out),      32'(model_bus()));
        check("ra_q",         32'(ra_q),         32'(m_ra));
        check("rb_q",         32'(rb_q),         32'(m_rb));
        check("rz_q",         32'(rz_q),         32'(m_rz));
        check("bus_conflict", 32'(bus_conflict), 32'(model_conflict()));
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input logic zo, input logic ao, input logic bo,
                                 input logic ai, input logic bi, input logic zi,
                                 input logic [W-1:0] add_imm,
                                 input logic [W-1:0] imm);
        RZout = zo; RAout = ao; RBout = bo;
        RAin  = ai; RBin  = bi; RZin  = zi;
        AddImmediate       = add_imm;
        RegisterAImmediate = imm;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    logic exp_conf;

    initial begin
        clear = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        stepCycle();
        check_en = 1'b1;
        check("reset ra", 32'(ra_q), 32'h00);
        check("reset rb", 32'(rb_q), 32'h00);
        check("reset rz", 32'(rz_q), 32'h00);
        clear = 1'b0;

        // Fill all registers, then clear mid-cycle with enables asserted
        applyStimulus(0, 0, 0, 1, 1, 1, 8'h00, 8'h5A);
        stepCycle();
        check("preload rz", 32'(rz_q), 32'h5A);
        applyStimulus(1, 0, 0, 1, 1, 1, 8'h11, 8'h22);
        #2 clear = 1'b1;
        #1;
        check("async clear ra", 32'(ra_q), 32'h00);
        check("async clear rb", 32'(rb_q), 32'h00);
        check("async clear rz", 32'(rz_q), 32'h00);
        stepCycle();
        check("clear held ra", 32'(ra_q), 32'h00);
        check("clear held rz", 32'(rz_q), 32'h00);

        // Load immediate into RA, released from clear in the same step
        clear = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0, 8'h00, 8'h05);
        #1 check("ldi bus", 32'(bus_out), 32'h05);
        stepCycle();
        check("ldi ra", 32'(ra_q), 32'h05);
        check("ldi rb", 32'(rb_q), 32'h00);
        check("ldi rz", 32'(rz_q), 32'h00);

        // RZ <= RA + 5
        applyStimulus(0, 1, 0, 0, 0, 1, 8'h05, 8'h00);
        #1 check("add bus", 32'(bus_out), 32'h05);
        stepCycle();
        check("add rz", 32'(rz_q), 32'h0A);

        // RB <= RZ
        applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        stepCycle();
        check("move rb", 32'(rb_q), 32'h0A);
        check("move ra", 32'(ra_q), 32'h05);

        // Wrap and accumulate
        applyStimulus(0, 0, 0, 1, 0, 0, 8'h00, 8'hFF);
        stepCycle();
        applyStimulus(0, 1, 0, 0, 0, 1, 8'h02, 8'h00);
        stepCycle();
        check("wrap rz", 32'(rz_q), 32'h01);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'h03, 8'h00);
        stepCycle();
        check("accum rz", 32'(rz_q), 32'h04);

        // Priority: RZ=0x0A, RA=0x05, RZout and RAout both asserted
        applyStimulus(0, 0, 0, 1, 0, 0, 8'h00, 8'h05);
        stepCycle();
        applyStimulus(0, 1, 0, 0, 0, 1, 8'h05, 8'h00);
        stepCycle();
        applyStimulus(1, 1, 0, 0, 1, 0, 8'h00, 8'h77);
`ifdef DATAPATH_BUS_CONFLICT_EN
        exp_conf = 1'b1;
`else
        exp_conf = 1'b0;
`endif
        #1 check("prio conflict", 32'(bus_conflict), 32'(exp_conf));
        check("prio bus", 32'(bus_out), 32'h0A);
        stepCycle();
        check("prio rb", 32'(rb_q), 32'h0A);

        // Same contention, but clear overrides the pending load
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 8'h33);
        stepCycle();
        check("rb preset", 32'(rb_q), 32'h33);
        applyStimulus(1, 1, 0, 0, 1, 0, 8'h00, 8'h00);
        clear = 1'b1;
        stepCycle();
        check("clear beats load rb", 32'(rb_q), 32'h00);
        clear = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        stepCycle();

        // Randomized phase, checked by the compare process
        for (int i = 0; i < 400; i++) begin
            logic zo, ao, bo;
            zo = ($urandom_range(0, 3) == 0);
            ao = ($urandom_range(0, 3) == 0);
            bo = ($urandom_range(0, 3) == 0);
`ifdef DATAPATH_BUS_CONFLICT_EN
            if (zo) begin ao = 1'b0; bo = 1'b0; end
            if (bo) ao = 1'b0;
`endif
            applyStimulus(zo, ao, bo,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          W'($urandom), W'($urandom));
            clear = ($urandom_range(0, 24) == 0);
            stepCycle();
        end

        clear = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        stepCycle();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
